// File: rtl/matmul_seq_pkg.sv
// Shared types and register map for the matrix-multiply job sequencer.
// Offsets are byte offsets from the accelerator control base.
package matmul_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    LOAD_A,
    LOAD_B,
    GO,
    WAIT,
    READ_C,
    PUSH
  } state_t;

  localparam logic [31:0] REG_OP_OFFSET   = 32'd0;
  localparam logic [31:0] REG_WA_OFFSET   = 32'd4;
  localparam logic [31:0] REG_HA_OFFSET   = 32'd8;
  localparam logic [31:0] REG_WB_OFFSET   = 32'd12;
  localparam logic [31:0] REG_HB_OFFSET   = 32'd16;
  localparam logic [31:0] REG_GO_OFFSET   = 32'd20;
  localparam logic [31:0] MATRIX_A_OFFSET = 32'd24;

  localparam logic [31:0] GO_VALUE = 32'hFFFF_FFFF;

  localparam logic [2:0] LAST_CFG_INDEX = 3'd4;

  // Config writes go out in the order op, wA, hA, wB, hB.
  function automatic logic [31:0] cfg_offset(input logic [2:0] k);
    logic [31:0] off;
    case (k)
      3'd0:    off = REG_OP_OFFSET;
      3'd1:    off = REG_WA_OFFSET;
      3'd2:    off = REG_HA_OFFSET;
      3'd3:    off = REG_WB_OFFSET;
      default: off = REG_HB_OFFSET;
    endcase
    return off;
  endfunction

  function automatic logic [31:0] elem_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/matmul_job_sequencer_if.sv
// Wishbone master bus between the job sequencer and the accelerator slave port.
interface matmul_job_sequencer_if;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_data_o;
  logic [31:0] m_data_i;
  logic        m_ack_i;

  modport master (
    output m_cyc_o, m_stb_o, m_we_o, m_addr_o, m_data_o,
    input  m_data_i, m_ack_i
  );

  modport slave (
    input  m_cyc_o, m_stb_o, m_we_o, m_addr_o, m_data_o,
    output m_data_i, m_ack_i
  );
endinterface

// File: rtl/wb_single_master.sv
// Single-transfer Wishbone engine: one request in, one ack or timeout out.
// Bus signals are held stable from issue until the ack cycle, then cyc/stb drop.
module wb_single_master #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        timeout,
  matmul_job_sequencer_if.master wb
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;

  // The timeout expires on the ACK_TIMEOUT-th edge that sees stb high without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb.m_cyc_o  <= 1'b0;
      wb.m_stb_o  <= 1'b0;
      wb.m_we_o   <= 1'b0;
      wb.m_addr_o <= '0;
      wb.m_data_o <= '0;
      ack         <= 1'b0;
      rdata       <= '0;
      timeout     <= 1'b0;
      to_cnt      <= '0;
    end else begin
      ack     <= 1'b0;
      timeout <= 1'b0;
      if (wb.m_stb_o) begin
        if (wb.m_ack_i) begin
          wb.m_cyc_o <= 1'b0;
          wb.m_stb_o <= 1'b0;
          ack        <= 1'b1;
          rdata      <= wb.m_data_i;
        end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
          wb.m_cyc_o <= 1'b0;
          wb.m_stb_o <= 1'b0;
          timeout    <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else if (req) begin
        wb.m_cyc_o  <= 1'b1;
        wb.m_stb_o  <= 1'b1;
        wb.m_we_o   <= wr;
        wb.m_addr_o <= addr;
        wb.m_data_o <= wdata;
        to_cnt      <= '0;
      end
    end
  end

endmodule

// File: rtl/matmul_job_sequencer.sv
// Runs one full matrix-multiply job on the accelerator: configure, load A and B,
// kick off compute, wait, then stream C back out.
module matmul_job_sequencer #(
  parameter logic [31:0] CTRL_BASE    = 32'h3200_0000,
  parameter int          TYPE_BW      = 8,
  parameter int          MAX_DIM      = 16,
  parameter int          COMPUTE_WAIT = 64,
  parameter int          ACK_TIMEOUT  = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start,
  input  logic [31:0]        op,
  input  logic [4:0]         dim,
  input  logic               in_valid,
  input  logic [TYPE_BW-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [31:0]        out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  matmul_job_sequencer_if.master wb
);

  import matmul_seq_pkg::*;

  localparam int IDX_W  = $clog2(MAX_DIM * MAX_DIM) + 1;
  localparam int WAIT_W = $clog2(COMPUTE_WAIT + 1);

  state_t              state;
  logic [31:0]         op_q;
  logic [4:0]          dim_q;
  logic [IDX_W-1:0]    nn_q;
  logic [IDX_W-1:0]    idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                pending;

  logic                req;
  logic                req_wr;
  logic [31:0]         req_addr;
  logic [31:0]         req_wdata;
  logic                xfer_ack;
  logic [31:0]         xfer_rdata;
  logic                xfer_timeout;

  logic                issue_wr;
  logic [31:0]         issue_addr;
  logic [31:0]         issue_wdata;
  logic [31:0]         a_base;
  logic [31:0]         b_base;
  logic [31:0]         c_base;
  logic [31:0]         in_ext;
  logic                last_elem;

  wb_single_master #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_wb (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .req     (req),
    .wr      (req_wr),
    .addr    (req_addr),
    .wdata   (req_wdata),
    .ack     (xfer_ack),
    .rdata   (xfer_rdata),
    .timeout (xfer_timeout),
    .wb      (wb)
  );

  assign a_base    = CTRL_BASE + MATRIX_A_OFFSET;
  assign b_base    = a_base + (32'(nn_q) << 2);
  assign c_base    = b_base + (32'(nn_q) << 2);
  assign in_ext    = {{(32-TYPE_BW){in_data[TYPE_BW-1]}}, in_data};
  assign last_elem = (idx == nn_q - IDX_W'(1));

  // Address and data of the transfer the current state would issue next.
  always_comb begin
    issue_wr    = 1'b1;
    issue_addr  = CTRL_BASE + cfg_offset(idx[2:0]);
    issue_wdata = (idx == '0) ? op_q : 32'(dim_q);
    case (state)
      LOAD_A: begin
        issue_addr  = elem_addr(a_base, 32'(idx));
        issue_wdata = in_ext;
      end
      LOAD_B: begin
        issue_addr  = elem_addr(b_base, 32'(idx));
        issue_wdata = in_ext;
      end
      GO: begin
        issue_addr  = CTRL_BASE + REG_GO_OFFSET;
        issue_wdata = GO_VALUE;
      end
      READ_C: begin
        issue_wr    = 1'b0;
        issue_addr  = elem_addr(c_base, 32'(idx));
        issue_wdata = '0;
      end
      default: ;
    endcase
  end

  // Request fields are registered every cycle; the engine only samples them with req.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      req_wr    <= issue_wr;
      req_addr  <= issue_addr;
      req_wdata <= issue_wdata;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      op_q      <= '0;
      dim_q     <= '0;
      nn_q      <= '0;
      idx       <= '0;
      wait_cnt  <= '0;
      pending   <= 1'b0;
      req       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      req  <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      if (xfer_timeout) begin
        state     <= IDLE;
        busy      <= 1'b0;
        err       <= 1'b1;
        pending   <= 1'b0;
        in_ready  <= 1'b0;
        out_valid <= 1'b0;
        idx       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op_q  <= op;
              dim_q <= dim;
              if (dim == 5'd0 || 32'(dim) > 32'(MAX_DIM)) begin
                err <= 1'b1;
              end else begin
                nn_q  <= IDX_W'(dim) * IDX_W'(dim);
                idx   <= '0;
                busy  <= 1'b1;
                state <= CFG;
              end
            end
          end
          CFG: begin
            if (!pending) begin
              req     <= 1'b1;
              pending <= 1'b1;
            end else if (xfer_ack) begin
              pending <= 1'b0;
              if (idx[2:0] == LAST_CFG_INDEX) begin
                idx   <= '0;
                state <= LOAD_A;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          // in_ready is only offered while no transfer is outstanding.
          LOAD_A, LOAD_B: begin
            if (pending) begin
              if (xfer_ack) begin
                pending <= 1'b0;
                if (last_elem) begin
                  idx   <= '0;
                  state <= (state == LOAD_A) ? LOAD_B : GO;
                end else begin
                  idx <= idx + 1'b1;
                end
              end
            end else if (in_ready) begin
              if (in_valid) begin
                in_ready <= 1'b0;
                req      <= 1'b1;
                pending  <= 1'b1;
              end
            end else begin
              in_ready <= 1'b1;
            end
          end
          GO: begin
            if (!pending) begin
              req     <= 1'b1;
              pending <= 1'b1;
            end else if (xfer_ack) begin
              pending  <= 1'b0;
              wait_cnt <= '0;
              state    <= WAIT;
            end
          end
          WAIT: begin
            if (wait_cnt == WAIT_W'(COMPUTE_WAIT - 1)) begin
              wait_cnt <= '0;
              idx      <= '0;
              state    <= READ_C;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          READ_C: begin
            if (!pending) begin
              req     <= 1'b1;
              pending <= 1'b1;
            end else if (xfer_ack) begin
              pending   <= 1'b0;
              out_data  <= xfer_rdata;
              out_valid <= 1'b1;
              state     <= PUSH;
            end
          end
          // The next read waits until the sink has taken the current element.
          PUSH: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (last_elem) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                idx   <= '0;
                state <= IDLE;
              end else begin
                idx   <= idx + 1'b1;
                state <= READ_C;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Directed bench for matmul_job_sequencer with a behavioural accelerator slave.
module tb_matmul_job_sequencer;

  localparam logic [31:0] CTRL = 32'h3200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op = '0;
  logic [4:0]  dim = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  logic        s_ack = 1'b0;
  logic [31:0] s_rdata = '0;

  matmul_job_sequencer_if bus();
  assign bus.m_ack_i  = s_ack;
  assign bus.m_data_i = s_rdata;

  matmul_job_sequencer #(
    .CTRL_BASE(CTRL), .TYPE_BW(8), .MAX_DIM(16), .COMPUTE_WAIT(64), .ACK_TIMEOUT(255)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .op(op), .dim(dim),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .wb(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad = 0;

  logic [7:0]  elems  [8]  = '{8'hFD, 8'hF1, 8'hFA, 8'h07, 8'h09, 8'hF1, 8'hFE, 8'hFB};
  logic [31:0] exp_c  [4]  = '{32'h0000_0003, 32'h0000_0078, 32'hFFFF_FFBC, 32'h0000_0037};
  logic [31:0] exp_wa [14] = '{32'h3200_0000, 32'h3200_0004, 32'h3200_0008, 32'h3200_000C,
                               32'h3200_0010, 32'h3200_0018, 32'h3200_001C, 32'h3200_0020,
                               32'h3200_0024, 32'h3200_0028, 32'h3200_002C, 32'h3200_0030,
                               32'h3200_0034, 32'h3200_0014};
  logic [31:0] exp_wd [14] = '{32'h1, 32'h2, 32'h2, 32'h2, 32'h2,
                               32'hFFFF_FFFD, 32'hFFFF_FFF1, 32'hFFFF_FFFA, 32'h0000_0007,
                               32'h0000_0009, 32'hFFFF_FFF1, 32'hFFFF_FFFE, 32'hFFFF_FFFB,
                               32'hFFFF_FFFF};
  logic [31:0] exp_ra [4]  = '{32'h3200_0038, 32'h3200_003C, 32'h3200_0040, 32'h3200_0044};

  bit [31:0]   mem [bit [31:0]];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];
  logic [31:0] out_q[$];
  bit          noack_en = 1'b0;
  logic [31:0] noack_addr = '0;
  bit          go_seen = 1'b0;

  int done_count = 0, err_count = 0, cyc_cycles = 0, busy_cycles = 0;
  int proto_err = 0, stable_err = 0, run = 0, last_run = 0;
  int stall_len = 0, hold_cnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Behavioural accelerator: the go write computes C = A*B from its own memory.
  task automatic modelWrite(input logic [31:0] a, input logic [31:0] d);
    int n;
    int s;
    logic [31:0] ab, bb, cb;
    mem[a] = d;
    if (a == CTRL + 32'd20 && d == 32'hFFFF_FFFF) begin
      go_seen = 1'b1;
      n  = int'(mem[CTRL + 32'd4]);
      ab = CTRL + 32'd24;
      bb = ab + 32'(4 * n * n);
      cb = bb + 32'(4 * n * n);
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++) begin
          s = 0;
          for (int k = 0; k < n; k++)
            s += $signed(mem[ab + 32'(4 * (i * n + k))]) * $signed(mem[bb + 32'(4 * (k * n + j))]);
          mem[cb + 32'(4 * (i * n + j))] = s;
        end
    end
  endtask

  always @(posedge clk) begin
    if (rst) s_ack <= 1'b0;
    else if (s_ack) s_ack <= 1'b0;
    else if (bus.m_cyc_o && bus.m_stb_o && !(noack_en && bus.m_addr_o == noack_addr)) begin
      s_ack <= 1'b1;
      if (bus.m_we_o) begin
        wr_addr_q.push_back(bus.m_addr_o);
        wr_data_q.push_back(bus.m_data_o);
        modelWrite(bus.m_addr_o, bus.m_data_o);
      end else begin
        rd_addr_q.push_back(bus.m_addr_o);
        s_rdata <= mem.exists(bus.m_addr_o) ? mem[bus.m_addr_o] : 32'h0;
      end
    end
  end

  logic        p_stb = 1'b0, p_acked = 1'b0, hold_flag = 1'b0;
  logic [64:0] p_bus = '0;
  logic [31:0] held_data = '0;

  // Bus and stream monitor: stability while waiting, idle cycle after ack, run length.
  always @(posedge clk) begin
    if (rst) begin
      p_stb = 1'b0; p_acked = 1'b0; hold_flag = 1'b0;
      if (run != 0) last_run = run;
      run = 0;
    end else begin
      if (bus.m_cyc_o) cyc_cycles++;
      if (busy) busy_cycles++;
      if (done) done_count++;
      if (err) err_count++;
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (p_acked && bus.m_cyc_o) proto_err++;
      if (p_stb && !p_acked && bus.m_stb_o && {bus.m_we_o, bus.m_addr_o, bus.m_data_o} != p_bus) proto_err++;
      if (bus.m_stb_o && !bus.m_cyc_o) proto_err++;
      p_acked = bus.m_stb_o && bus.m_ack_i;
      p_stb   = bus.m_stb_o;
      p_bus   = {bus.m_we_o, bus.m_addr_o, bus.m_data_o};
      if (bus.m_stb_o) begin
        if (bus.m_ack_i) run = 0; else run++;
      end else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      if (hold_flag && (!out_valid || out_data != held_data)) stable_err++;
      hold_flag = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  always @(negedge clk) begin
    if (!out_valid) begin
      out_ready = 1'b0;
      hold_cnt  = 0;
    end else if (hold_cnt < stall_len) begin
      out_ready = 1'b0;
      hold_cnt++;
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic clearLogs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); out_q.delete();
    go_seen = 1'b0;
  endtask

  task automatic startJob(input logic [4:0] d, input logic [31:0] o);
    @(negedge clk);
    start = 1'b1; dim = d; op = o;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int count, input int gap);
    bit ok;
    for (int i = 0; i < count; i++) begin
      repeat (gap) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = elems[i];
      ok = 1'b0;
      for (int t = 0; t < 3000; t++) begin
        if (in_ready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) begin
        in_valid = 1'b0;
        checkOutput("src_wait", 32'(ok), 32'd1);
        return;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic waitJobEnd(input int d0, input int e0);
    bit ok = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (done_count != d0 || err_count != e0) begin ok = 1'b1; break; end
    end
    if (!ok) checkOutput("job_end_wait", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkJob(input string tag);
    checkOutput({tag, "_out_count"}, 32'(out_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < out_q.size(); i++)
      checkOutput($sformatf("%s_c%0d", tag, i), out_q[i], exp_c[i]);
    checkOutput({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'd14);
    for (int i = 0; i < 14 && i < wr_addr_q.size(); i++) begin
      checkOutput($sformatf("%s_wa%0d", tag, i), wr_addr_q[i], exp_wa[i]);
      checkOutput($sformatf("%s_wd%0d", tag, i), wr_data_q[i], exp_wd[i]);
    end
    checkOutput({tag, "_rd_count"}, 32'(rd_addr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++)
      checkOutput($sformatf("%s_ra%0d", tag, i), rd_addr_q[i], exp_ra[i]);
    checkOutput({tag, "_proto"}, 32'(proto_err), 32'd0);
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic runJob(input string tag, input int gap, input int stall);
    int d0, e0;
    clearLogs();
    stall_len = stall;
    d0 = done_count; e0 = err_count;
    startJob(5'd2, 32'd1);
    applyStimulus(8, gap);
    waitJobEnd(d0, e0);
    checkJob(tag);
    checkOutput({tag, "_done_pulses"}, 32'(done_count - d0), 32'd1);
    checkOutput({tag, "_no_err"}, 32'(err_count - e0), 32'd0);
    stall_len = 0;
  endtask

  initial begin
    int d0, e0, c0, b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cyc", 32'(bus.m_cyc_o), 32'd0);
    checkOutput("rst_stb", 32'(bus.m_stb_o), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_done_err", {30'd0, done, err}, 32'd0);

    $display("[TB] basic dim=2 job");
    runJob("basic", 0, 0);

    $display("[TB] illegal dimensions");
    e0 = err_count; c0 = cyc_cycles; b0 = busy_cycles;
    startJob(5'd0, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("dim0_err", 32'(err_count - e0), 32'd1);
    startJob(5'd17, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("dim17_err", 32'(err_count - e0), 32'd2);
    checkOutput("illegal_no_cyc", 32'(cyc_cycles - c0), 32'd0);
    checkOutput("illegal_no_busy", 32'(busy_cycles - b0), 32'd0);

    $display("[TB] stalled source and sink");
    stable_err = 0;
    runJob("stall", 5, 7);
    checkOutput("stall_out_stable", 32'(stable_err), 32'd0);

    $display("[TB] ack timeout on third config write");
    clearLogs();
    noack_en = 1'b1; noack_addr = CTRL + 32'd8; last_run = 0;
    d0 = done_count; e0 = err_count;
    startJob(5'd2, 32'd1);
    waitJobEnd(d0, e0);
    checkOutput("to_err", 32'(err_count - e0), 32'd1);
    checkOutput("to_stb_cycles", 32'(last_run), 32'd255);
    checkOutput("to_cyc_low", 32'(bus.m_cyc_o), 32'd0);
    checkOutput("to_idle", 32'(busy), 32'd0);
    checkOutput("to_acked_writes", 32'(wr_addr_q.size()), 32'd2);
    noack_en = 1'b0;
    runJob("after_timeout", 0, 0);

    $display("[TB] reset during LOAD_B");
    clearLogs();
    startJob(5'd2, 32'd1);
    applyStimulus(6, 0);
    repeat (2) @(negedge clk);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_cyc", 32'(bus.m_cyc_o), 32'd0);
    checkOutput("async_rst_stb", 32'(bus.m_stb_o), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runJob("after_reset", 0, 0);

    $display("[TB] start pulsed during WAIT");
    clearLogs();
    d0 = done_count; e0 = err_count;
    startJob(5'd2, 32'd1);
    applyStimulus(8, 0);
    for (int t = 0; t < 500 && !go_seen; t++) @(negedge clk);
    checkOutput("go_seen", 32'(go_seen), 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("wait_busy", 32'(busy), 32'd1);
    startJob(5'd3, 32'd9);
    waitJobEnd(d0, e0);
    checkJob("wait_start");
    c0 = cyc_cycles;
    repeat (30) @(negedge clk);
    checkOutput("wait_start_no_second_job", 32'(cyc_cycles - c0), 32'd0);
    checkOutput("wait_start_done_once", 32'(done_count - d0), 32'd1);
    checkOutput("wait_start_outputs", 32'(out_q.size()), 32'd4);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
